exe_stage_mc: RTL and testbench

EXE_STAGE_MC -- requirements
Module: exe_stage_mc

---
 rtl/exe_stage_mc.sv | 223 ++++++++++++++++++++++
 tb/tb_exe_stage_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with forwarding muxes, a single-cycle ALU,
// an iterative shift-add multiplier and branch resolution. Results are
// registered, and a small IDLE/MUL/DONE controller sequences them.
module exe_stage_mc #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [3:0]       EXE_CMD,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [WIDTH-1:0] reg_2,
  input  logic [1:0]       sel_A,
  input  logic [1:0]       sel_B,
  input  logic [1:0]       sel_ST,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  input  logic [WIDTH-1:0] PC,
  input  logic [1:0]       Br_type,
  output logic             out_valid,
  output logic [WIDTH-1:0] ALU_result,
  output logic [WIDTH-1:0] st_data,
  output logic [WIDTH-1:0] Br_Addr,
  output logic             Br_taken,
  output logic             busy
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Forward select: 01 MEM, 10 WB, 00 and 11 the decoded value.
  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] dec,
                                               input logic [WIDTH-1:0] mem,
                                               input logic [WIDTH-1:0] wb);
    logic [WIDTH-1:0] r;
    case (sel)
      2'b01:   r = mem;
      2'b10:   r = wb;
      default: r = dec;
    endcase
    return r;
  endfunction

  // Single-cycle ALU; MUL is handled by the iterative unit, so it maps to 0 here.
  function automatic logic [WIDTH-1:0] alu(input logic [3:0] cmd,
                                           input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [SW-1:0]    sh;
    sh = b[SW-1:0];
    case (cmd)
      4'b0000: r = a + b;
      4'b0010: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b0110: r = ~(a | b);
      4'b0111: r = a ^ b;
      4'b1000: r = a << sh;
      4'b1001: r = $unsigned($signed(a) >>> sh);
      4'b1010: r = a >> sh;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] a_s, b_s, st_s, alu_s, acc_nxt_s;
  logic [3:0]       cmd_s;
  logic             is_mul_s, accept_s, br_s, mul_last_s;

  logic [WIDTH-1:0] mcand_r, mplier_r, acc_r;
  logic [SW-1:0]    cnt_r;
  logic             br_pend_r;
  logic             out_valid_r, br_taken_r;
  logic [WIDTH-1:0] alu_result_r, st_data_r, br_addr_r;

  assign out_valid  = out_valid_r;
  assign Br_taken   = br_taken_r;
  assign ALU_result = alu_result_r;
  assign st_data    = st_data_r;
  assign Br_Addr    = br_addr_r;

  // Operand selection, command remap, ALU, branch decision and multiplier step.
  always_comb begin
    a_s      = fwd_mux(sel_A, val1, mem_fwd, wb_fwd);
    b_s      = fwd_mux(sel_B, val2, mem_fwd, wb_fwd);
    st_s     = fwd_mux(sel_ST, reg_2, mem_fwd, wb_fwd);
    cmd_s    = EXE_CMD;
    is_mul_s = 1'b0;
    if (EXE_CMD == 4'b1100) begin
      if (MUL_EN != 0) begin
        is_mul_s = 1'b1;
      end else begin
        cmd_s = 4'b0000;
      end
    end else begin
      is_mul_s = 1'b0;
    end
    alu_s = alu(cmd_s, a_s, b_s);
    case (Br_type)
      2'b01:   br_s = (a_s == {WIDTH{1'b0}});
      2'b10:   br_s = (a_s != st_s);
      2'b11:   br_s = 1'b1;
      default: br_s = 1'b0;
    endcase
    acc_nxt_s  = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
    mul_last_s = (cnt_r == SW'(WIDTH - 1));
    accept_s   = in_valid & in_ready & ~flush;
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Controller next-state logic; flush wins over accept and over completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (in_valid) begin
          state_nxt_s = is_mul_s ? ST_MUL : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (mul_last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Controller outputs, decoded from state only.
  always_comb begin
    in_ready = 1'b1;
    busy     = 1'b0;
    case (state_r)
      ST_MUL: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
    endcase
  end

  // Datapath registers: capture on accept, iterate the multiply, present results.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      br_taken_r   <= 1'b0;
      br_pend_r    <= 1'b0;
      alu_result_r <= {WIDTH{1'b0}};
      st_data_r    <= {WIDTH{1'b0}};
      br_addr_r    <= {WIDTH{1'b0}};
      mcand_r      <= {WIDTH{1'b0}};
      mplier_r     <= {WIDTH{1'b0}};
      acc_r        <= {WIDTH{1'b0}};
      cnt_r        <= {SW{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
      br_taken_r  <= 1'b0;
    end else if (accept_s) begin
      st_data_r <= st_s;
      br_addr_r <= PC + {b_s[WIDTH-3:0], 2'b00};
      if (is_mul_s) begin
        mcand_r     <= a_s;
        mplier_r    <= b_s;
        acc_r       <= {WIDTH{1'b0}};
        cnt_r       <= {SW{1'b0}};
        br_pend_r   <= br_s;
        out_valid_r <= 1'b0;
        br_taken_r  <= 1'b0;
      end else begin
        alu_result_r <= alu_s;
        out_valid_r  <= 1'b1;
        br_taken_r   <= br_s;
      end
    end else if (state_r == ST_MUL) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + SW'(1);
      if (mul_last_s) begin
        alu_result_r <= acc_nxt_s;
        out_valid_r  <= 1'b1;
        br_taken_r   <= br_pend_r;
      end else begin
        out_valid_r <= 1'b0;
        br_taken_r  <= 1'b0;
      end
    end else begin
      out_valid_r <= 1'b0;
      br_taken_r  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: a WIDTH=32 instance for the main checks and
// a WIDTH=16 instance for the narrow multiply.
module tb_exe_stage_mc;

  logic        clk, rst, flush, in_valid, in_ready;
  logic [3:0]  cmd;
  logic [31:0] val1, val2, reg_2, mem_fwd, wb_fwd, pc;
  logic [1:0]  sel_a, sel_b, sel_st, br_type;
  logic        out_valid, br_taken, busy;
  logic [31:0] alu_result, st_data, br_addr;

  logic        in_valid16, in_ready16, ov16, bt16, busy16;
  logic [3:0]  cmd16;
  logic [15:0] v1_16, v2_16, res16, st16, ba16;

  int vecs = 0;
  int errs = 0;

  exe_stage_mc #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .EXE_CMD(cmd), .val1(val1), .val2(val2), .reg_2(reg_2),
    .sel_A(sel_a), .sel_B(sel_b), .sel_ST(sel_st), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .PC(pc), .Br_type(br_type), .out_valid(out_valid), .ALU_result(alu_result),
    .st_data(st_data), .Br_Addr(br_addr), .Br_taken(br_taken), .busy(busy));

  exe_stage_mc #(.WIDTH(16), .MUL_EN(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .flush(1'b0),
    .EXE_CMD(cmd16), .val1(v1_16), .val2(v2_16), .reg_2(16'h0000),
    .sel_A(2'b00), .sel_B(2'b00), .sel_ST(2'b00), .mem_fwd(16'h0000), .wb_fwd(16'h0000),
    .PC(16'h0000), .Br_type(2'b00), .out_valid(ov16), .ALU_result(res16),
    .st_data(st16), .Br_Addr(ba16), .Br_taken(bt16), .busy(busy16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; flush = 1'b0; cmd = 4'b0000;
    val1 = 32'd0; val2 = 32'd0; reg_2 = 32'd0; mem_fwd = 32'd0; wb_fwd = 32'd0;
    pc = 32'd0; sel_a = 2'b00; sel_b = 2'b00; sel_st = 2'b00; br_type = 2'b00;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] st, input logic [31:0] p, input logic [1:0] bt);
    in_valid = 1'b1; cmd = c; val1 = a; val2 = b; reg_2 = st; pc = p; br_type = bt;
  endtask

  task automatic test_reset();
    idle_in();
    in_valid16 = 1'b0; cmd16 = 4'b0000; v1_16 = 16'd0; v2_16 = 16'd0;
    rst = 1'b1;
    drive(4'b0000, 32'd1, 32'd2, 32'd3, 32'd4, 2'b11);
    tick(); tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vecs++; if (alu_result !== 32'd0) begin errs++; $display("FAIL reset_alu got %h want 0", alu_result); end
    vecs++; if (br_taken !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL reset_br_busy got %b%b want 00", br_taken, busy); end
    vecs++; if (st_data !== 32'd0 || br_addr !== 32'd0) begin errs++; $display("FAIL reset_st_addr got %h %h want 0 0", st_data, br_addr); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0;
    idle_in();
    tick();
  endtask

  task automatic test_add();
    drive(4'b0000, 32'd7, 32'd5, 32'd0, 32'd0, 2'b00);
    tick();
    idle_in();
    vecs++; if (out_valid !== 1'b1 || alu_result !== 32'd12) begin errs++; $display("FAIL add got v=%b r=%0d want v=1 r=12", out_valid, alu_result); end
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL done_to_idle out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_forward();
    drive(4'b0010, 32'd999, 32'd888, 32'd0, 32'd0, 2'b00);
    sel_a = 2'b01; mem_fwd = 32'd100; sel_b = 2'b10; wb_fwd = 32'd30;
    tick();
    idle_in();
    vecs++; if (alu_result !== 32'd70) begin errs++; $display("FAIL fwd_sub got %0d want 70", alu_result); end
    drive(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h1234, 32'd0, 2'b00);
    sel_a = 2'b11; sel_st = 2'b01; mem_fwd = 32'hABCD;
    tick();
    idle_in();
    vecs++; if (alu_result !== 32'hF000F000) begin errs++; $display("FAIL fwd_sel11 got %h want f000f000", alu_result); end
    vecs++; if (st_data !== 32'hABCD) begin errs++; $display("FAIL fwd_st got %h want abcd", st_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  c_t [10];
    logic [31:0] a_t [10];
    logic [31:0] b_t [10];
    logic [31:0] e_t [10];
    c_t = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b0011};
    a_t = '{32'hFFFFFFFF, 32'd3, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
            32'd1, 32'h80000000, 32'h80000000, 32'd5};
    b_t = '{32'd2, 32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
            32'h23, 32'd4, 32'd4, 32'd6};
    e_t = '{32'd1, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h000F000F, 32'h0FF00FF0,
            32'd8, 32'hF8000000, 32'h08000000, 32'd0};
    for (int i = 0; i < 10; i++) begin
      drive(c_t[i], a_t[i], b_t[i], 32'd0, 32'd0, 2'b00);
      tick();
      vecs++;
      if (out_valid !== 1'b1 || alu_result !== e_t[i]) begin
        errs++;
        $display("FAIL b2b_op%0d cmd=%b got v=%b r=%h want v=1 r=%h", i, c_t[i], out_valid, alu_result, e_t[i]);
      end
    end
    idle_in();
    tick();
  endtask

  task automatic test_branch();
    drive(4'b0000, 32'd5, 32'd4, 32'd5, 32'h100, 2'b10);
    tick();
    vecs++; if (br_taken !== 1'b0 || br_addr !== 32'h110) begin errs++; $display("FAIL bne_eq got t=%b a=%h want t=0 a=110", br_taken, br_addr); end
    drive(4'b0000, 32'd5, 32'd4, 32'd6, 32'h100, 2'b10);
    tick();
    vecs++; if (br_taken !== 1'b1) begin errs++; $display("FAIL bne_ne got %b want 1", br_taken); end
    drive(4'b0000, 32'd0, 32'd1, 32'd0, 32'h200, 2'b01);
    tick();
    vecs++; if (br_taken !== 1'b1 || br_addr !== 32'h204) begin errs++; $display("FAIL bez_zero got t=%b a=%h want t=1 a=204", br_taken, br_addr); end
    drive(4'b0000, 32'd9, 32'd0, 32'd0, 32'h0, 2'b01);
    tick();
    vecs++; if (br_taken !== 1'b0) begin errs++; $display("FAIL bez_nz got %b want 0", br_taken); end
    drive(4'b0000, 32'd9, 32'd0, 32'd0, 32'h0, 2'b11);
    tick();
    idle_in();
    vecs++; if (br_taken !== 1'b1) begin errs++; $display("FAIL jmp got %b want 1", br_taken); end
    tick();
    vecs++; if (br_taken !== 1'b0) begin errs++; $display("FAIL br_drop got %b want 0", br_taken); end
  endtask

  task automatic test_mul();
    int busy_cnt = 0;
    int ov_seen = 0;
    drive(4'b1100, 32'hFFFFFFFF, 32'd3, 32'd0, 32'd0, 2'b00);
    tick();
    drive(4'b0000, 32'd1, 32'd1, 32'd0, 32'd0, 2'b00);
    sel_a = 2'b01; sel_b = 2'b01;
    for (int i = 1; i <= 32; i++) begin
      if (busy === 1'b1 && in_ready === 1'b0) busy_cnt++;
      if (out_valid === 1'b1) ov_seen++;
      mem_fwd = 32'(i * 32'h01010101);
      if (i == 32) in_valid = 1'b0;
      tick();
    end
    idle_in();
    vecs++; if (busy_cnt != 32 || ov_seen != 0) begin errs++; $display("FAIL mul_busy got busy=%0d ov=%0d want 32 0", busy_cnt, ov_seen); end
    vecs++; if (out_valid !== 1'b1 || alu_result !== 32'hFFFFFFFD || busy !== 1'b0) begin
      errs++; $display("FAIL mul_result got v=%b r=%h b=%b want v=1 r=fffffffd b=0", out_valid, alu_result, busy);
    end
    tick();
  endtask

  task automatic test_flush();
    int ov_seen = 0;
    drive(4'b1100, 32'd7, 32'd9, 32'd0, 32'd0, 2'b00);
    tick();
    idle_in();
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    drive(4'b0000, 32'd1, 32'd1, 32'd0, 32'd0, 2'b00);
    tick();
    idle_in();
    vecs++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL flush_mul got rdy=%b busy=%b v=%b want 1 0 0", in_ready, busy, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) ov_seen++;
      tick();
    end
    vecs++; if (ov_seen != 0) begin errs++; $display("FAIL flush_no_result got %0d valid cycles want 0", ov_seen); end
    drive(4'b0000, 32'd1, 32'd2, 32'd0, 32'd0, 2'b11);
    tick();
    flush = 1'b1;
    drive(4'b0000, 32'd3, 32'd4, 32'd0, 32'd0, 2'b11);
    tick();
    idle_in();
    vecs++; if (out_valid !== 1'b0 || br_taken !== 1'b0) begin errs++; $display("FAIL flush_prio got v=%b t=%b want 0 0", out_valid, br_taken); end
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL flush_drop got %b want 0", out_valid); end
  endtask

  task automatic test_rst_mid_mul();
    drive(4'b1100, 32'd11, 32'd13, 32'h55, 32'h40, 2'b11);
    tick();
    idle_in();
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++; if (out_valid !== 1'b0 || br_taken !== 1'b0 || busy !== 1'b0 || alu_result !== 32'd0 ||
                st_data !== 32'd0 || br_addr !== 32'd0) begin
      errs++; $display("FAIL rst_mul got v=%b t=%b b=%b r=%h s=%h a=%h want all 0",
                       out_valid, br_taken, busy, alu_result, st_data, br_addr);
    end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", in_ready); end
    tick();
  endtask

  task automatic test_mul16();
    int cyc = 1;
    in_valid16 = 1'b1; cmd16 = 4'b1100; v1_16 = 16'd300; v2_16 = 16'd300;
    tick();
    in_valid16 = 1'b0;
    while (ov16 !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    vecs++; if (cyc != 17) begin errs++; $display("FAIL mul16_latency got %0d want 17", cyc); end
    vecs++; if (res16 !== 16'h5F90) begin errs++; $display("FAIL mul16_result got %h want 5f90", res16); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_back_to_back();
    test_branch();
    test_mul();
    test_flush();
    test_rst_mid_mul();
    test_mul16();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
